mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the SRAM and mem_arbiter.
// slave = arbiter view, master = requester/SRAM environment view.
interface mem_arbiter_if #(
  parameter int AWIDTH = 10
);
  logic              I_REQ;
  logic [11:0]       I_ADDR;
  logic              I_ACK;
  logic [31:0]       I_RDATA;

  logic              D_REQ;
  logic              D_WE;
  logic [3:0]        D_BE;
  logic [11:0]       D_ADDR;
  logic [31:0]       D_WDATA;
  logic              D_ACK;
  logic [31:0]       D_RDATA;

  logic              M_CSN;
  logic              M_WEN;
  logic [3:0]        M_BE;
  logic [AWIDTH-1:0] M_ADDR;
  logic [31:0]       M_DI;
  logic [31:0]       M_DOUT;

  logic [31:0]       CONFLICT_CNT;

  modport slave (
    input  I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_DOUT,
    output I_ACK, I_RDATA, D_ACK, D_RDATA,
           M_CSN, M_WEN, M_BE, M_ADDR, M_DI, CONFLICT_CNT
  );

  modport master (
    output I_REQ, I_ADDR, D_REQ, D_WE, D_BE, D_ADDR, D_WDATA, M_DOUT,
    input  I_ACK, I_RDATA, D_ACK, D_RDATA,
           M_CSN, M_WEN, M_BE, M_ADDR, M_DI, CONFLICT_CNT
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single-port synchronous SRAM.
// Define ARB_PERF_CNT_EN to build the conflict-cycle counter; otherwise CONFLICT_CNT is 0.
module mem_arbiter #(
  parameter int AWIDTH = 10,
  parameter bit D_PRIO = 1'b1
) (
  input logic         CLK,
  input logic         RSTn,
  mem_arbiter_if.slave bus
);

  logic              i_ack_q;
  logic              d_ack_q;
  logic              last_d_q;
  logic              i_elig;
  logic              d_elig;
  logic              conflict;
  logic              grant_i;
  logic              grant_d;
  logic              m_csn;
  logic              m_wen;
  logic [3:0]        m_be;
  logic [AWIDTH-1:0] m_addr;
  logic [31:0]       m_di;
  logic              unused_addr_bits;

  // A port whose ACK is showing this cycle is still busy, so it cannot reissue yet.
  assign i_elig   = RSTn & bus.I_REQ & ~i_ack_q;
  assign d_elig   = RSTn & bus.D_REQ & ~d_ack_q;
  assign conflict = i_elig & d_elig;

  always_comb begin
    grant_d = 1'b0;
    grant_i = 1'b0;
    if (D_PRIO) begin
      grant_d = d_elig;
      grant_i = i_elig & ~d_elig;
    end else begin
      grant_d = d_elig & (~i_elig | ~last_d_q);
      grant_i = i_elig & (~d_elig | last_d_q);
    end
  end

  always_comb begin
    m_csn  = 1'b1;
    m_wen  = 1'b1;
    m_be   = 4'b0000;
    m_addr = '0;
    m_di   = '0;
    if (grant_d) begin
      m_csn  = 1'b0;
      m_wen  = ~bus.D_WE;
      m_be   = bus.D_WE ? bus.D_BE : 4'b0000;
      m_addr = bus.D_ADDR[AWIDTH+1:2];
      m_di   = bus.D_WDATA;
    end else if (grant_i) begin
      m_csn  = 1'b0;
      m_addr = bus.I_ADDR[AWIDTH+1:2];
    end
  end

  // last_d_q = 0 means I won the last conflict, so the first conflict after reset goes to D.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      i_ack_q  <= 1'b0;
      d_ack_q  <= 1'b0;
      last_d_q <= 1'b0;
    end else begin
      i_ack_q <= grant_i;
      d_ack_q <= grant_d;
      if (conflict) begin
        last_d_q <= grant_d;
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic [31:0] conflict_cnt_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      conflict_cnt_q <= '0;
    end else if (conflict) begin
      conflict_cnt_q <= conflict_cnt_q + 32'd1;
    end
  end

  assign bus.CONFLICT_CNT = conflict_cnt_q;
`else
  assign bus.CONFLICT_CNT = '0;
`endif

  assign bus.M_CSN   = m_csn;
  assign bus.M_WEN   = m_wen;
  assign bus.M_BE    = m_be;
  assign bus.M_ADDR  = m_addr;
  assign bus.M_DI    = m_di;

  assign bus.I_ACK   = i_ack_q & RSTn;
  assign bus.D_ACK   = d_ack_q & RSTn;
  assign bus.I_RDATA = bus.M_DOUT;
  assign bus.D_RDATA = bus.M_DOUT;

  // Byte-offset bits never reach the word-addressed SRAM.
  assign unused_addr_bits = ^{bus.I_ADDR[1:0], bus.D_ADDR[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one D-priority and one round-robin instance,
// each attached to its own behavioural synchronous SRAM.
module tb_mem_arbiter;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.AWIDTH(10)) bp ();
  mem_arbiter_if #(.AWIDTH(10)) br ();

  mem_arbiter #(.AWIDTH(10), .D_PRIO(1'b1)) dut_p (.CLK(CLK), .RSTn(RSTn), .bus(bp.slave));
  mem_arbiter #(.AWIDTH(10), .D_PRIO(1'b0)) dut_r (.CLK(CLK), .RSTn(RSTn), .bus(br.slave));

  logic [31:0] mem_p [0:1023];
  logic [31:0] mem_r [0:1023];

  always @(posedge CLK) begin
    if (!bp.M_CSN) begin
      if (!bp.M_WEN) begin
        for (int b = 0; b < 4; b++)
          if (bp.M_BE[b]) mem_p[bp.M_ADDR][8*b +: 8] <= bp.M_DI[8*b +: 8];
      end else begin
        bp.M_DOUT <= mem_p[bp.M_ADDR];
      end
    end
  end

  always @(posedge CLK) begin
    if (!br.M_CSN) begin
      if (!br.M_WEN) begin
        for (int b = 0; b < 4; b++)
          if (br.M_BE[b]) mem_r[br.M_ADDR][8*b +: 8] <= br.M_DI[8*b +: 8];
      end else begin
        br.M_DOUT <= mem_r[br.M_ADDR];
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic        is_d;
    logic        we;
    logic [3:0]  be;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [9:0]  exp_maddr;
    logic        exp_wen;
    logic [3:0]  exp_be;
    logic        chk_rd;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  int exp_cf;
  int icnt, dcnt, acnt;

  initial begin
    for (int k = 0; k < 1024; k++) begin
      mem_p[k] = 32'hA500_0000 | k;
      mem_r[k] = 32'hA500_0000 | k;
    end
    mem_p[2] = 32'h1122_3344;

    bp.I_REQ = 1'b1; bp.I_ADDR = 12'h010; bp.D_REQ = 1'b1; bp.D_WE = 1'b1;
    bp.D_BE = 4'hF; bp.D_ADDR = 12'h020; bp.D_WDATA = 32'h0; bp.M_DOUT = 32'h0;
    br.I_REQ = 1'b0; br.I_ADDR = 12'h0; br.D_REQ = 1'b0; br.D_WE = 1'b0;
    br.D_BE = 4'h0; br.D_ADDR = 12'h0; br.D_WDATA = 32'h0; br.M_DOUT = 32'h0;

    //              is_d we  be     addr     wdata         maddr   wen  be    chk  rdata
    vecs[0] = '{1'b0, 1'b0, 4'h0, 12'h010, 32'h0,        10'h004, 1'b1, 4'h0, 1'b1, 32'hA500_0004};
    vecs[1] = '{1'b1, 1'b1, 4'h3, 12'h008, 32'hDEADBEEF, 10'h002, 1'b0, 4'h3, 1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 4'h0, 12'h008, 32'h0,        10'h002, 1'b1, 4'h0, 1'b1, 32'h1122_BEEF};
    vecs[3] = '{1'b1, 1'b1, 4'hF, 12'hFFF, 32'h12345678, 10'h3FF, 1'b0, 4'hF, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b0, 4'h0, 12'hFFC, 32'h0,        10'h3FF, 1'b1, 4'h0, 1'b1, 32'h1234_5678};
    vecs[5] = '{1'b1, 1'b0, 4'h0, 12'h013, 32'h0,        10'h004, 1'b1, 4'h0, 1'b1, 32'hA500_0004};
    vecs[6] = '{1'b1, 1'b0, 4'hF, 12'h020, 32'hCAFEF00D, 10'h008, 1'b1, 4'h0, 1'b1, 32'hA500_0008};

    // Reset with both requests high: SRAM must stay idle.
    #12;
    chk("rst_csn", {31'b0, bp.M_CSN}, 32'd1);
    chk("rst_wen", {31'b0, bp.M_WEN}, 32'd1);
    chk("rst_be", {28'b0, bp.M_BE}, 32'd0);
    chk("rst_acks", {30'b0, bp.I_ACK, bp.D_ACK}, 32'd0);
    chk("rst_cnt", bp.CONFLICT_CNT, 32'd0);
    bp.I_REQ = 1'b0; bp.D_REQ = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    tick();

    // Single accesses on the D-priority instance.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].is_d) begin
        bp.D_REQ = 1'b1; bp.D_WE = vecs[i].we; bp.D_BE = vecs[i].be;
        bp.D_ADDR = vecs[i].addr; bp.D_WDATA = vecs[i].wdata;
      end else begin
        bp.I_REQ = 1'b1; bp.I_ADDR = vecs[i].addr;
      end
      @(negedge CLK);
      chk($sformatf("v%0d_csn", i), {31'b0, bp.M_CSN}, 32'd0);
      chk($sformatf("v%0d_maddr", i), {22'b0, bp.M_ADDR}, {22'b0, vecs[i].exp_maddr});
      chk($sformatf("v%0d_wen", i), {31'b0, bp.M_WEN}, {31'b0, vecs[i].exp_wen});
      chk($sformatf("v%0d_be", i), {28'b0, bp.M_BE}, {28'b0, vecs[i].exp_be});
      if (vecs[i].is_d) chk($sformatf("v%0d_di", i), bp.M_DI, vecs[i].wdata);
      tick();
      @(negedge CLK);
      if (vecs[i].is_d) begin
        chk($sformatf("v%0d_dack", i), {30'b0, bp.I_ACK, bp.D_ACK}, 32'd1);
        if (vecs[i].chk_rd) chk($sformatf("v%0d_drdata", i), bp.D_RDATA, vecs[i].exp_rdata);
      end else begin
        chk($sformatf("v%0d_iack", i), {30'b0, bp.I_ACK, bp.D_ACK}, 32'd2);
        if (vecs[i].chk_rd) chk($sformatf("v%0d_irdata", i), bp.I_RDATA, vecs[i].exp_rdata);
      end
      chk($sformatf("v%0d_no_reissue", i), {31'b0, bp.M_CSN}, 32'd1);
      bp.I_REQ = 1'b0; bp.D_REQ = 1'b0;
      tick();
      @(negedge CLK);
      chk($sformatf("v%0d_ack_off", i), {30'b0, bp.I_ACK, bp.D_ACK}, 32'd0);
      chk($sformatf("v%0d_idle", i), {bp.M_CSN, bp.M_WEN, bp.M_BE, 16'b0, bp.M_ADDR}, {1'b1, 1'b1, 30'b0});
      chk($sformatf("v%0d_idle_di", i), bp.M_DI, 32'd0);
      tick();
    end

    // Simultaneous requests, D priority: D in N, I in N+1.
    bp.I_ADDR = 12'h010; bp.D_ADDR = 12'h020; bp.D_WE = 1'b0; bp.D_BE = 4'h0;
    bp.I_REQ = 1'b1; bp.D_REQ = 1'b1;
    @(negedge CLK);
    chk("cf_n_maddr", {bp.M_CSN, 21'b0, bp.M_ADDR}, 32'd8);
    tick();
    @(negedge CLK);
    chk("cf_n1_acks", {30'b0, bp.I_ACK, bp.D_ACK}, 32'd1);
    chk("cf_n1_drdata", bp.D_RDATA, 32'hA500_0008);
    chk("cf_n1_i_issue", {bp.M_CSN, 21'b0, bp.M_ADDR}, 32'd4);
    bp.D_REQ = 1'b0;
    tick();
    @(negedge CLK);
    chk("cf_n2_acks", {30'b0, bp.I_ACK, bp.D_ACK}, 32'd2);
    chk("cf_n2_irdata", bp.I_RDATA, 32'hA500_0004);
    bp.I_REQ = 1'b0;
    tick();
`ifdef ARB_PERF_CNT_EN
    exp_cf = 1;
`else
    exp_cf = 0;
`endif
    chk("cf_cnt_p1", bp.CONFLICT_CNT, exp_cf);

    // Both held for 20 cycles, D priority: I takes every D ACK cycle.
    icnt = 0; dcnt = 0;
    bp.I_REQ = 1'b1; bp.D_REQ = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      if (bp.D_ACK) begin
        dcnt++;
        chk($sformatf("hold_k%0d_i_in_dack", k), {bp.M_CSN, 21'b0, bp.M_ADDR}, 32'd4);
      end
      if (bp.I_ACK) icnt++;
      tick();
    end
    bp.I_REQ = 1'b0; bp.D_REQ = 1'b0;
    tick();
    tick();
    chk("hold_dcnt", dcnt, 32'd10);
    chk("hold_icnt", icnt, 32'd9);
`ifdef ARB_PERF_CNT_EN
    exp_cf = 2;
`else
    exp_cf = 0;
`endif
    chk("cf_cnt_p2", bp.CONFLICT_CNT, exp_cf);

    // Round-robin: continuous requests alternate D, I, D, I ...
    acnt = 0;
    br.I_ADDR = 12'h010; br.D_ADDR = 12'h020; br.D_WE = 1'b0;
    br.I_REQ = 1'b1; br.D_REQ = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge CLK);
      if (k < 8)
        chk($sformatf("rr_k%0d_grant", k), {br.M_CSN, 21'b0, br.M_ADDR}, (k % 2 == 0) ? 32'd8 : 32'd4);
      if (br.I_ACK) acnt++;
      if (br.D_ACK) acnt++;
      if (k == 8) begin
        br.I_REQ = 1'b0; br.D_REQ = 1'b0;
      end
      tick();
    end
    tick();
    chk("rr_ack_total", acnt, 32'd8);

    // Second fresh conflict goes to I because D won the previous one.
    br.I_REQ = 1'b1; br.D_REQ = 1'b1;
    @(negedge CLK);
    chk("rr2_i_wins", {br.M_CSN, 21'b0, br.M_ADDR}, 32'd4);
    tick();
    @(negedge CLK);
    chk("rr2_iack", {30'b0, br.I_ACK, br.D_ACK}, 32'd2);
    chk("rr2_irdata", br.I_RDATA, 32'hA500_0004);
    chk("rr2_d_issue", {br.M_CSN, 21'b0, br.M_ADDR}, 32'd8);
    br.I_REQ = 1'b0;
    tick();
    @(negedge CLK);
    chk("rr2_dack", {30'b0, br.I_ACK, br.D_ACK}, 32'd1);
    chk("rr2_drdata", br.D_RDATA, 32'hA500_0008);
    br.D_REQ = 1'b0;
    tick();
`ifdef ARB_PERF_CNT_EN
    exp_cf = 2;
`else
    exp_cf = 0;
`endif
    chk("cf_cnt_r", br.CONFLICT_CNT, exp_cf);

    // Reset right after a D issue drops the access; held request reissues after release.
    bp.D_ADDR = 12'h020; bp.D_WE = 1'b0; bp.D_REQ = 1'b1;
    @(negedge CLK);
    chk("rmid_issue", {31'b0, bp.M_CSN}, 32'd0);
    @(posedge CLK);
    #1 RSTn = 1'b0;
    #1;
    chk("rmid_no_dack", {31'b0, bp.D_ACK}, 32'd0);
    chk("rmid_csn", {31'b0, bp.M_CSN}, 32'd1);
    chk("rmid_cnt", bp.CONFLICT_CNT, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    #1;
    chk("rmid_reissue", {bp.M_CSN, 21'b0, bp.M_ADDR}, 32'd8);
    tick();
    @(negedge CLK);
    chk("rmid_dack", {30'b0, bp.I_ACK, bp.D_ACK}, 32'd1);
    chk("rmid_drdata", bp.D_RDATA, 32'hA500_0008);
    bp.D_REQ = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
